// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: request/ack bus transaction, load alignment and extension.
// Optional build macro MISALIGN_FAULT_EN: misaligned halfword/word accesses fault without a bus cycle.
module mem_access_unit #(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ_EN_EXMEM,
  input  logic        MEM_WRITE_EN_EXMEM,
  input  logic [2:0]  FUNCT3_EXMEM,
  input  logic [31:0] ALU_RES_EXMEM,
  input  logic [31:0] STORE_DATA_EXMEM,
  output logic        MEM_BUSYWAIT,
  output logic [31:0] MEM_READ_MEM,
  output logic        ACCESS_FAULT,
  output logic        DM_REQ,
  output logic        DM_WE,
  output logic [31:0] DM_ADDR,
  output logic [31:0] DM_WDATA,
  output logic [3:0]  DM_BYTE_EN,
  input  logic [31:0] DM_RDATA,
  input  logic        DM_ACK
);

  typedef enum logic [1:0] {IDLE = 2'b00, WAIT = 2'b01, DONE = 2'b10} state_t;

  state_t      state_r, state_s;
  logic [7:0]  wait_cnt_r;
  logic [2:0]  funct3_r;
  logic [1:0]  lane_r;
  logic        op_valid_s, illegal_s, misalign_s, reject_s, timeout_s;

  function automatic logic [31:0] load_align(input logic [31:0] rdata, input logic [1:0] lane,
                                             input logic [2:0] funct3);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h000000, b};
      3'b101:  return {16'h0000, h};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] store_lanes(input logic [1:0] lane, input logic [2:0] funct3);
    case (funct3)
      3'b000:  return 4'b0001 << lane;
      3'b001:  return 4'b0011 << {lane[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] data, input logic [2:0] funct3);
    case (funct3)
      3'b000:  return {4{data[7:0]}};
      3'b001:  return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  assign op_valid_s = MEM_READ_EN_EXMEM | MEM_WRITE_EN_EXMEM;
  assign illegal_s  = (MEM_READ_EN_EXMEM & MEM_WRITE_EN_EXMEM)
                    | (FUNCT3_EXMEM == 3'b011) | (FUNCT3_EXMEM == 3'b110) | (FUNCT3_EXMEM == 3'b111)
                    | (MEM_WRITE_EN_EXMEM & ((FUNCT3_EXMEM == 3'b100) | (FUNCT3_EXMEM == 3'b101)));
`ifdef MISALIGN_FAULT_EN
  assign misalign_s = ((FUNCT3_EXMEM[1:0] == 2'b01) & ALU_RES_EXMEM[0])
                    | ((FUNCT3_EXMEM[1:0] == 2'b10) & (ALU_RES_EXMEM[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif
  assign reject_s  = illegal_s | misalign_s;
  assign timeout_s = (wait_cnt_r == 8'(MAX_WAIT - 1));

  // Stall is combinational so the pipeline freezes in the same cycle the op appears; reset forces it low.
  assign MEM_BUSYWAIT = ~RESET & (((state_r == IDLE) & op_valid_s) | (state_r == WAIT));

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (op_valid_s) state_s = reject_s ? DONE : WAIT;
        else            state_s = IDLE;
      end
      WAIT: begin
        if (DM_ACK || timeout_s) state_s = DONE;
        else                     state_s = WAIT;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Bus outputs, request context, wait counter, result and fault registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      DM_REQ       <= 1'b0;
      DM_WE        <= 1'b0;
      DM_ADDR      <= 32'h0000_0000;
      DM_WDATA     <= 32'h0000_0000;
      DM_BYTE_EN   <= 4'b0000;
      MEM_READ_MEM <= 32'h0000_0000;
      ACCESS_FAULT <= 1'b0;
      wait_cnt_r   <= 8'h00;
      funct3_r     <= 3'b000;
      lane_r       <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (op_valid_s && reject_s) begin
            ACCESS_FAULT <= 1'b1;
            MEM_READ_MEM <= 32'h0000_0000;
          end else if (op_valid_s) begin
            DM_REQ     <= 1'b1;
            DM_WE      <= MEM_WRITE_EN_EXMEM;
            DM_ADDR    <= {ALU_RES_EXMEM[31:2], 2'b00};
            DM_WDATA   <= MEM_WRITE_EN_EXMEM ? store_data(STORE_DATA_EXMEM, FUNCT3_EXMEM) : 32'h0000_0000;
            DM_BYTE_EN <= MEM_WRITE_EN_EXMEM ? store_lanes(ALU_RES_EXMEM[1:0], FUNCT3_EXMEM) : 4'b1111;
            funct3_r   <= FUNCT3_EXMEM;
            lane_r     <= ALU_RES_EXMEM[1:0];
            wait_cnt_r <= 8'h00;
          end else begin
            ACCESS_FAULT <= 1'b0;
          end
        end
        WAIT: begin
          if (DM_ACK) begin
            DM_REQ <= 1'b0;
            if (!DM_WE) MEM_READ_MEM <= load_align(DM_RDATA, lane_r, funct3_r);
            else        MEM_READ_MEM <= MEM_READ_MEM;
          end else if (timeout_s) begin
            DM_REQ       <= 1'b0;
            MEM_READ_MEM <= 32'h0000_0000;
            ACCESS_FAULT <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'h01;
          end
        end
        DONE:    ACCESS_FAULT <= 1'b0;
        default: ACCESS_FAULT <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (MAX_WAIT=4); honours MISALIGN_FAULT_EN when defined.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MEM_READ_EN_EXMEM, MEM_WRITE_EN_EXMEM;
  logic [2:0]  FUNCT3_EXMEM;
  logic [31:0] ALU_RES_EXMEM, STORE_DATA_EXMEM;
  logic        MEM_BUSYWAIT;
  logic [31:0] MEM_READ_MEM;
  logic        ACCESS_FAULT, DM_REQ, DM_WE;
  logic [31:0] DM_ADDR, DM_WDATA, DM_RDATA;
  logic [3:0]  DM_BYTE_EN;
  logic        DM_ACK;

  int vectors = 0;
  int miscompares = 0;

  mem_access_unit #(.MAX_WAIT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .MEM_READ_EN_EXMEM(MEM_READ_EN_EXMEM), .MEM_WRITE_EN_EXMEM(MEM_WRITE_EN_EXMEM),
    .FUNCT3_EXMEM(FUNCT3_EXMEM), .ALU_RES_EXMEM(ALU_RES_EXMEM), .STORE_DATA_EXMEM(STORE_DATA_EXMEM),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .MEM_READ_MEM(MEM_READ_MEM), .ACCESS_FAULT(ACCESS_FAULT),
    .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
    .DM_BYTE_EN(DM_BYTE_EN), .DM_RDATA(DM_RDATA), .DM_ACK(DM_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op in an IDLE cycle, runs n_req request cycles (ack in cycle ack_at, 0 = never)
  // and returns while the unit sits in DONE.
  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata, input int n_req,
                        input int ack_at, input logic [31:0] rdata, input logic exp_we,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata);
    @(negedge CLK);
    MEM_READ_EN_EXMEM = rd; MEM_WRITE_EN_EXMEM = wr; FUNCT3_EXMEM = f3;
    ALU_RES_EXMEM = addr; STORE_DATA_EXMEM = sdata;
    #1;
    chk({tag, " busy c0"}, MEM_BUSYWAIT, 1'b1);
    chk({tag, " req c0"}, DM_REQ, 1'b0);
    for (int c = 1; c <= n_req; c++) begin
      @(negedge CLK);
      if (c == ack_at) begin DM_ACK = 1'b1; DM_RDATA = rdata; end
      chk({tag, " req"}, DM_REQ, 1'b1);
      chk({tag, " busy"}, MEM_BUSYWAIT, 1'b1);
      if (c == 1) begin
        chk({tag, " we"}, DM_WE, exp_we);
        chk({tag, " addr"}, DM_ADDR, exp_addr);
        chk({tag, " be"}, DM_BYTE_EN, exp_be);
        chk({tag, " wdata"}, DM_WDATA, exp_wdata);
      end
    end
    @(negedge CLK);
    DM_ACK = 1'b0; DM_RDATA = 32'h0; MEM_READ_EN_EXMEM = 1'b0; MEM_WRITE_EN_EXMEM = 1'b0;
    chk({tag, " busy done"}, MEM_BUSYWAIT, 1'b0);
    chk({tag, " req done"}, DM_REQ, 1'b0);
  endtask

  initial begin
    RESET = 1'b1;
    MEM_READ_EN_EXMEM = 1'b0; MEM_WRITE_EN_EXMEM = 1'b0; FUNCT3_EXMEM = 3'b000;
    ALU_RES_EXMEM = 32'h0; STORE_DATA_EXMEM = 32'h0; DM_RDATA = 32'h0; DM_ACK = 1'b0;
    #3;
    chk("rst busy", MEM_BUSYWAIT, 1'b0);
    chk("rst req", DM_REQ, 1'b0);
    chk("rst read", MEM_READ_MEM, 32'h0);
    chk("rst fault", ACCESS_FAULT, 1'b0);
    chk("rst addr", DM_ADDR, 32'h0);
    chk("rst be", DM_BYTE_EN, 4'h0);
    @(negedge CLK);
    RESET = 1'b0;

    access("LW", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 2, 2, 32'hDEADBEEF, 1'b0, 32'h100, 4'hF, 32'h0);
    chk("LW read", MEM_READ_MEM, 32'hDEADBEEF);
    chk("LW fault", ACCESS_FAULT, 1'b0);
    @(negedge CLK);
    chk("idle busy", MEM_BUSYWAIT, 1'b0);
    chk("idle hold", MEM_READ_MEM, 32'hDEADBEEF);

    access("LB", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 1, 32'h80FF1234, 1'b0, 32'h100, 4'hF, 32'h0);
    chk("LB read", MEM_READ_MEM, 32'hFFFFFF80);
    access("LBU", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 1, 32'h80FF1234, 1'b0, 32'h100, 4'hF, 32'h0);
    chk("LBU read", MEM_READ_MEM, 32'h00000080);
    access("LHU", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 1, 1, 32'h80FF1234, 1'b0, 32'h100, 4'hF, 32'h0);
    chk("LHU read", MEM_READ_MEM, 32'h000080FF);
    access("LH", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 3, 3, 32'h80FF1234, 1'b0, 32'h100, 4'hF, 32'h0);
    chk("LH read", MEM_READ_MEM, 32'hFFFF80FF);

    access("SH", 1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 1, 1, 32'h12345678, 1'b1, 32'h100, 4'b1100, 32'hABCDABCD);
    chk("SH read kept", MEM_READ_MEM, 32'hFFFF80FF);
    chk("SH fault", ACCESS_FAULT, 1'b0);
    access("SB", 1'b0, 1'b1, 3'b000, 32'h101, 32'h000000A5, 2, 2, 32'h0, 1'b1, 32'h100, 4'b0010, 32'hA5A5A5A5);
    access("SW", 1'b0, 1'b1, 3'b010, 32'h104, 32'h11223344, 1, 1, 32'h0, 1'b1, 32'h104, 4'b1111, 32'h11223344);
    chk("SW read kept", MEM_READ_MEM, 32'hFFFF80FF);

    access("TMO", 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 4, 0, 32'h0, 1'b0, 32'h200, 4'hF, 32'h0);
    chk("TMO fault", ACCESS_FAULT, 1'b1);
    chk("TMO read", MEM_READ_MEM, 32'h0);
    @(negedge CLK);
    chk("TMO fault clr", ACCESS_FAULT, 1'b0);

`ifdef MISALIGN_FAULT_EN
    MEM_READ_EN_EXMEM = 1'b1; FUNCT3_EXMEM = 3'b010; ALU_RES_EXMEM = 32'h102;
    #1;
    chk("MIS busy c0", MEM_BUSYWAIT, 1'b1);
    @(negedge CLK);
    MEM_READ_EN_EXMEM = 1'b0;
    chk("MIS req", DM_REQ, 1'b0);
    chk("MIS busy", MEM_BUSYWAIT, 1'b0);
    chk("MIS fault", ACCESS_FAULT, 1'b1);
    chk("MIS read", MEM_READ_MEM, 32'h0);
`else
    access("MIS", 1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 1, 1, 32'hCAFEF00D, 1'b0, 32'h100, 4'hF, 32'h0);
    chk("MIS read", MEM_READ_MEM, 32'hCAFEF00D);
    chk("MIS fault", ACCESS_FAULT, 1'b0);
`endif

    @(negedge CLK);
    MEM_READ_EN_EXMEM = 1'b1; MEM_WRITE_EN_EXMEM = 1'b1; FUNCT3_EXMEM = 3'b010; ALU_RES_EXMEM = 32'h10;
    #1;
    chk("ILL busy c0", MEM_BUSYWAIT, 1'b1);
    @(negedge CLK);
    MEM_READ_EN_EXMEM = 1'b0; MEM_WRITE_EN_EXMEM = 1'b0;
    chk("ILL req", DM_REQ, 1'b0);
    chk("ILL busy", MEM_BUSYWAIT, 1'b0);
    chk("ILL fault", ACCESS_FAULT, 1'b1);
    @(negedge CLK);
    MEM_WRITE_EN_EXMEM = 1'b1; FUNCT3_EXMEM = 3'b100; ALU_RES_EXMEM = 32'h20;
    #1;
    chk("ILLS busy c0", MEM_BUSYWAIT, 1'b1);
    @(negedge CLK);
    MEM_WRITE_EN_EXMEM = 1'b0;
    chk("ILLS req", DM_REQ, 1'b0);
    chk("ILLS fault", ACCESS_FAULT, 1'b1);

    access("PRE", 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1, 1, 32'h5A5A5A5A, 1'b0, 32'h300, 4'hF, 32'h0);
    @(negedge CLK);
    MEM_READ_EN_EXMEM = 1'b1; FUNCT3_EXMEM = 3'b010; ALU_RES_EXMEM = 32'h400;
    @(negedge CLK);
    chk("RST req c1", DM_REQ, 1'b1);
    @(negedge CLK);
    chk("RST req c2", DM_REQ, 1'b1);
    RESET = 1'b1;
    #1;
    chk("RST req async", DM_REQ, 1'b0);
    chk("RST busy async", MEM_BUSYWAIT, 1'b0);
    chk("RST read async", MEM_READ_MEM, 32'h0);
    chk("RST addr async", DM_ADDR, 32'h0);
    MEM_READ_EN_EXMEM = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("RST idle busy", MEM_BUSYWAIT, 1'b0);
    chk("RST idle req", DM_REQ, 1'b0);
    chk("RST idle fault", ACCESS_FAULT, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- MEM-stage data-memory access controller. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Turns the load/store in EX/MEM into a multi-cycle request/acknowledge transaction on the data-memory bus.
- Aligns, sign- or zero-extends load data into `MEM_READ_MEM`.
- Holds `MEM_BUSYWAIT` high to freeze the pipeline until the access completes or faults.

## Interface
- `MAX_WAIT`, 255: maximum cycles in WAIT without `DM_ACK` before the access aborts (1..255).
- `CLK` in 1: clock, rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `MEM_READ_EN_EXMEM` in 1: load in EX/MEM.
- `MEM_WRITE_EN_EXMEM` in 1: store in EX/MEM.
- `FUNCT3_EXMEM` in 3: access size/sign. 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `ALU_RES_EXMEM` in 32: byte address.
- `STORE_DATA_EXMEM` in 32: rs2 store data.
- `MEM_BUSYWAIT` out 1: pipeline stall. EX/MEM and MEM/WB hold while high.
- `MEM_READ_MEM` out 32: aligned, extended load result.
- `ACCESS_FAULT` out 1: access faulted. Valid in DONE only.
- `DM_REQ` out 1: bus request.
- `DM_WE` out 1: 1 = write.
- `DM_ADDR` out 32: word address, `{addr[31:2],2'b00}`.
- `DM_WDATA` out 32: lane-replicated store data.
- `DM_BYTE_EN` out 4: byte lanes.
- `DM_RDATA` in 32: read data, valid with `DM_ACK`.
- `DM_ACK` in 1: transfer complete. Sampled only while `DM_REQ`=1.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- Reset values: all outputs 0, result register 0, wait counter 0.
- **Op valid** = `MEM_READ_EN_EXMEM` | `MEM_WRITE_EN_EXMEM`.
- **Illegal** = both enables high, or funct3 in {011, 110, 111}, or a store with funct3 in {100, 101}.
- IDLE, no op: `MEM_BUSYWAIT`=0, `MEM_READ_MEM` holds its last value.
- IDLE, op valid: `MEM_BUSYWAIT`=1, combinationally, in the same cycle.
  - Illegal (or misaligned, see Configuration): go to DONE with fault set, no bus cycle.
  - Otherwise: register the bus outputs, set `DM_REQ`=1, clear the counter, go to WAIT.
- WAIT: `MEM_BUSYWAIT`=1. Bus outputs stay stable.
  - `DM_ACK`=1: `DM_REQ`=0, capture the aligned load result (stores leave the result register unchanged), go to DONE.
  - Otherwise the counter increments. At counter = `MAX_WAIT`-1 with no ack: `DM_REQ`=0, result=0, fault set, go to DONE.
- DONE: `MEM_BUSYWAIT`=0, `ACCESS_FAULT`=fault flag. Always go to IDLE at the next edge; EX/MEM advances on that same edge.
- Store lanes:
  - SB: `DM_BYTE_EN`=0001<<addr[1:0], `DM_WDATA`={4{data[7:0]}}.
  - SH: `DM_BYTE_EN`=0011<<{addr[1],1'b0}, `DM_WDATA`={2{data[15:0]}}.
  - SW: `DM_BYTE_EN`=1111, `DM_WDATA`=data.
- Loads: `DM_WE`=0, `DM_BYTE_EN`=1111, `DM_WDATA`=0.
  - Byte lane selected by addr[1:0]; halfword selected by addr[1].
  - LB/LH sign-extend. LBU/LHU zero-extend. LW passes through.
- Extension is applied on capture, using the address and funct3 registered at request time.

## Timing
- Best-case load/store: op at cycle 0, `DM_REQ` cycles 1..k, ack in cycle k, DONE in cycle k+1.
- `MEM_BUSYWAIT` is high for cycles 0..k and low in DONE.
- Fault path (no bus cycle): busy for cycle 0 only; DONE in cycle 1.
- `DM_ACK` arriving in the same cycle `DM_REQ` rises (k=1) is legal.
- Inputs are stable while `MEM_BUSYWAIT`=1, because EX/MEM is held.
- `RESET` mid-transaction: immediately forces IDLE and `DM_REQ`=0, independent of the clock. The transaction is discarded. The bus slave must drop any in-flight access on reset.
- Back-to-back ops: a new op appears in the cycle after DONE and is treated as a fresh IDLE request.

## Configuration
- `MISALIGN_FAULT_EN` defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]≠0, is treated as illegal.
  - No bus cycle is issued; `ACCESS_FAULT`=1 in DONE and the result register is cleared.
- `MISALIGN_FAULT_EN` undefined:
  - Halfwords ignore addr[0]; words ignore addr[1:0].
  - The access proceeds normally.

## Test plan
- LW 0x100, `DM_ACK` in the 2nd `DM_REQ` cycle, `DM_RDATA`=0xDEADBEEF -> `DM_ADDR`=0x100, `MEM_BUSYWAIT` high 3 cycles, `MEM_READ_MEM`=0xDEADBEEF in DONE, `ACCESS_FAULT`=0.
- LB 0x103, `DM_RDATA`=0x80FF1234 -> 0xFFFFFF80. LBU same -> 0x00000080. LHU 0x102 -> 0x000080FF.
- SH 0x102, data 0x0000ABCD -> `DM_WE`=1, `DM_ADDR`=0x100, `DM_BYTE_EN`=1100, `DM_WDATA`=0xABCDABCD. After ack, `MEM_READ_MEM` is unchanged.
- `MAX_WAIT`=4, LW with `DM_ACK` never asserted -> `DM_REQ` high 4 cycles then low, DONE with `ACCESS_FAULT`=1, `MEM_READ_MEM`=0.
- LW 0x102 -> with `MISALIGN_FAULT_EN`: no `DM_REQ`, busy 1 cycle, fault=1. Without it: `DM_ADDR`=0x100, full word returned.
- `RESET` pulsed in WAIT cycle 2 -> `DM_REQ`=0 and outputs 0 before the next edge. After release with no op, `MEM_BUSYWAIT`=0.
